// File: rtl/sa_cache_ctrl.sv
// rtl/sa_cache_ctrl.sv - blocking cache controller: lookup, write-back, refill, replay and timeout
// One request in flight; every output is registered from the next-state decode.
module sa_cache_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [31:0] i_req_addr,
  input  logic        i_req_we,
  input  logic [31:0] i_req_wdata,
  output logic        o_resp_valid,
  output logic [31:0] o_resp_rdata,
  output logic        o_resp_err,
  output logic [17:0] o_tag,
  output logic [7:0]  o_index,
  output logic [5:0]  o_offset,
  output logic [31:0] o_dataW,
  output logic        o_memRW,
  output logic        o_cache_access,
  input  logic        i_cache_miss,
  input  logic [31:0] i_cache_data,
  input  logic        i_evict,
  input  logic [31:0] i_evict_data,
  input  logic [31:0] i_evict_addr,
  output logic [31:0] o_memory_line,
  output logic        o_memory_response,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata
);

  typedef enum logic [2:0] {IDLE, LOOKUP, WB, FILL, REFILL, RESP} state_t;

  localparam logic [7:0] TMO = 8'(TIMEOUT_CYC);

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [31:0] ev_addr_q, ev_addr_d, ev_data_q, ev_data_d;
  logic [31:0] line_q, line_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        we_q, we_d, replay_q, replay_d;

  logic        req_ready_q, req_ready_d, cache_access_q, cache_access_d;
  logic        memrw_q, memrw_d, memresp_q, memresp_d;
  logic        mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic        resp_valid_q, resp_valid_d, resp_err_q, resp_err_d;
  logic [31:0] dataw_q, dataw_d, mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    ev_addr_d    = ev_addr_q;
    ev_data_d    = ev_data_q;
    line_d       = line_q;
    cnt_d        = cnt_q;
    replay_d     = replay_q;
    resp_rdata_d = '0;
    resp_err_d   = 1'b0;

    case (state_q)
      IDLE: if (i_req_valid) begin
        addr_d   = i_req_addr;
        we_d     = i_req_we;
        wdata_d  = i_req_wdata;
        replay_d = 1'b0;
        state_d  = LOOKUP;
      end
      LOOKUP: begin
        if (!i_cache_miss) begin
          resp_rdata_d = we_q ? 32'h0 : i_cache_data;
          state_d      = RESP;
        end else if (replay_q) begin
          // A miss after our own refill means the cache lost the line; give up rather than loop.
          resp_err_d = 1'b1;
          state_d    = RESP;
        end else if (i_evict) begin
          ev_addr_d = i_evict_addr;
          ev_data_d = i_evict_data;
          cnt_d     = '0;
          state_d   = WB;
        end else begin
          cnt_d   = '0;
          state_d = FILL;
        end
      end
      WB, FILL: begin
        if (i_mem_ack) begin
          if (state_q == FILL) begin
            line_d  = i_mem_rdata;
            state_d = REFILL;
          end else begin
            cnt_d   = '0;
            state_d = FILL;
          end
        end else if (cnt_q + 8'd1 == TMO) begin
          resp_err_d = 1'b1;
          state_d    = RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      REFILL: begin
        replay_d = 1'b1;
        state_d  = LOOKUP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    req_ready_d    = (state_d == IDLE);
    cache_access_d = (state_d == LOOKUP);
    memrw_d        = (state_d == LOOKUP) ? we_d : 1'b0;
    dataw_d        = (state_d == LOOKUP) ? wdata_d : 32'h0;
    mem_req_d      = (state_d == WB) || (state_d == FILL);
    mem_we_d       = (state_d == WB);
    mem_addr_d     = (state_d == WB)   ? ev_addr_d :
                     (state_d == FILL) ? {addr_d[31:6], 6'b0} : 32'h0;
    mem_wdata_d    = (state_d == WB) ? ev_data_d : 32'h0;
    memresp_d      = (state_d == REFILL);
    resp_valid_d   = (state_d == RESP);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      addr_q         <= '0;
      we_q           <= 1'b0;
      wdata_q        <= '0;
      ev_addr_q      <= '0;
      ev_data_q      <= '0;
      line_q         <= '0;
      cnt_q          <= '0;
      replay_q       <= 1'b0;
      req_ready_q    <= 1'b1;
      cache_access_q <= 1'b0;
      memrw_q        <= 1'b0;
      dataw_q        <= '0;
      mem_req_q      <= 1'b0;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
      memresp_q      <= 1'b0;
      resp_valid_q   <= 1'b0;
      resp_rdata_q   <= '0;
      resp_err_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      we_q           <= we_d;
      wdata_q        <= wdata_d;
      ev_addr_q      <= ev_addr_d;
      ev_data_q      <= ev_data_d;
      line_q         <= line_d;
      cnt_q          <= cnt_d;
      replay_q       <= replay_d;
      req_ready_q    <= req_ready_d;
      cache_access_q <= cache_access_d;
      memrw_q        <= memrw_d;
      dataw_q        <= dataw_d;
      mem_req_q      <= mem_req_d;
      mem_we_q       <= mem_we_d;
      mem_addr_q     <= mem_addr_d;
      mem_wdata_q    <= mem_wdata_d;
      memresp_q      <= memresp_d;
      resp_valid_q   <= resp_valid_d;
      resp_rdata_q   <= resp_rdata_d;
      resp_err_q     <= resp_err_d;
    end
  end

  assign o_req_ready       = req_ready_q;
  assign o_cache_access    = cache_access_q;
  assign o_tag             = addr_q[31:14];
  assign o_index           = addr_q[13:6];
  assign o_offset          = addr_q[5:0];
  assign o_memRW           = memrw_q;
  assign o_dataW           = dataw_q;
  assign o_memory_line     = line_q;
  assign o_memory_response = memresp_q;
  assign o_mem_req         = mem_req_q;
  assign o_mem_we          = mem_we_q;
  assign o_mem_addr        = mem_addr_q;
  assign o_mem_wdata       = mem_wdata_q;
  assign o_resp_valid      = resp_valid_q;
  assign o_resp_rdata      = resp_rdata_q;
  assign o_resp_err        = resp_err_q;

endmodule

// File: tb/tb_sa_cache_ctrl.sv
// tb/tb_sa_cache_ctrl.sv - directed checks of sa_cache_ctrl with TIMEOUT_CYC=4
module tb_sa_cache_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_req_valid = 1'b0, i_req_we = 1'b0;
  logic [31:0] i_req_addr = '0, i_req_wdata = '0;
  logic        i_cache_miss = 1'b0, i_evict = 1'b0, i_mem_ack = 1'b0;
  logic [31:0] i_cache_data = '0, i_evict_data = '0, i_evict_addr = '0, i_mem_rdata = '0;
  logic        o_req_ready, o_resp_valid, o_resp_err, o_memRW, o_cache_access;
  logic        o_memory_response, o_mem_req, o_mem_we;
  logic [31:0] o_resp_rdata, o_dataW, o_memory_line, o_mem_addr, o_mem_wdata;
  logic [17:0] o_tag;
  logic [7:0]  o_index;
  logic [5:0]  o_offset;

  int errors = 0;
  int checks = 0;

  sa_cache_ctrl #(.TIMEOUT_CYC(4)) dut (
    .clk(clk), .rst(rst),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_addr(i_req_addr),
    .i_req_we(i_req_we), .i_req_wdata(i_req_wdata),
    .o_resp_valid(o_resp_valid), .o_resp_rdata(o_resp_rdata), .o_resp_err(o_resp_err),
    .o_tag(o_tag), .o_index(o_index), .o_offset(o_offset),
    .o_dataW(o_dataW), .o_memRW(o_memRW), .o_cache_access(o_cache_access),
    .i_cache_miss(i_cache_miss), .i_cache_data(i_cache_data),
    .i_evict(i_evict), .i_evict_data(i_evict_data), .i_evict_addr(i_evict_addr),
    .o_memory_line(o_memory_line), .o_memory_response(o_memory_response),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [31:0] addr, input logic we, input logic [31:0] wd);
    i_req_valid = 1'b1;
    i_req_addr  = addr;
    i_req_we    = we;
    i_req_wdata = wd;
    tick;
    i_req_valid = 1'b0;
  endtask

  int  n_req;
  int  n_resp;
  logic got_resp, got_err;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(o_req_ready), 32'd1);
    chk("rst_memreq", 32'(o_mem_req), 32'd0);
    chk("rst_respv", 32'(o_resp_valid), 32'd0);
    chk("rst_access", 32'(o_cache_access), 32'd0);
    rst = 1'b1;
    i_mem_ack = 1'b1;
    tick;
    i_mem_ack = 1'b0;
    chk("idle_ack_ignored", 32'(o_req_ready), 32'd1);

    // read hit, stray ack during LOOKUP must not matter
    issue(32'h0000_4040, 1'b0, 32'h0);
    chk("hit_access", 32'(o_cache_access), 32'd1);
    chk("hit_ready", 32'(o_req_ready), 32'd0);
    chk("hit_tag", 32'(o_tag), 32'd1);
    chk("hit_index", 32'(o_index), 32'd1);
    chk("hit_offset", 32'(o_offset), 32'd0);
    chk("hit_memrw", 32'(o_memRW), 32'd0);
    i_cache_miss = 1'b0;
    i_cache_data = 32'hDEAD_BEEF;
    i_mem_ack    = 1'b1;
    tick;
    i_mem_ack = 1'b0;
    chk("hit_respv", 32'(o_resp_valid), 32'd1);
    chk("hit_rdata", o_resp_rdata, 32'hDEAD_BEEF);
    chk("hit_err", 32'(o_resp_err), 32'd0);
    chk("hit_access_done", 32'(o_cache_access), 32'd0);
    tick;
    chk("hit_respv_pulse", 32'(o_resp_valid), 32'd0);
    chk("hit_ready_back", 32'(o_req_ready), 32'd1);

    // clean read miss, ack in third FILL cycle
    issue(32'h1234_5678, 1'b0, 32'h0);
    i_cache_miss = 1'b1;
    i_evict      = 1'b0;
    tick;
    i_cache_miss = 1'b0;
    chk("cm_memreq", 32'(o_mem_req), 32'd1);
    chk("cm_memwe", 32'(o_mem_we), 32'd0);
    chk("cm_memaddr", o_mem_addr, 32'h1234_5640);
    tick;
    chk("cm_wait", 32'(o_mem_req), 32'd1);
    tick;
    i_mem_ack   = 1'b1;
    i_mem_rdata = 32'hCAFE_F00D;
    tick;
    i_mem_ack = 1'b0;
    chk("cm_memresp", 32'(o_memory_response), 32'd1);
    chk("cm_line", o_memory_line, 32'hCAFE_F00D);
    chk("cm_memreq_drop", 32'(o_mem_req), 32'd0);
    tick;
    chk("cm_memresp_pulse", 32'(o_memory_response), 32'd0);
    chk("cm_replay_access", 32'(o_cache_access), 32'd1);
    i_cache_data = 32'hCAFE_F00D;
    tick;
    chk("cm_respv", 32'(o_resp_valid), 32'd1);
    chk("cm_rdata", o_resp_rdata, 32'hCAFE_F00D);
    chk("cm_err", 32'(o_resp_err), 32'd0);
    tick;

    // dirty write miss: write-back then fill, exactly two memory requests
    issue(32'h0000_0100, 1'b1, 32'hA5A5_A5A5);
    chk("dm_memrw", 32'(o_memRW), 32'd1);
    chk("dm_dataw", o_dataW, 32'hA5A5_A5A5);
    i_cache_miss = 1'b1;
    i_evict      = 1'b1;
    i_evict_addr = 32'h0000_8000;
    i_evict_data = 32'h1111_1111;
    tick;
    i_cache_miss = 1'b0;
    i_evict      = 1'b0;
    i_evict_addr = 32'h0;
    i_evict_data = 32'h0;
    chk("dm_wb_req", 32'(o_mem_req), 32'd1);
    chk("dm_wb_we", 32'(o_mem_we), 32'd1);
    chk("dm_wb_addr", o_mem_addr, 32'h0000_8000);
    chk("dm_wb_data", o_mem_wdata, 32'h1111_1111);
    chk("dm_dataw_off", o_dataW, 32'h0);
    i_mem_ack   = 1'b1;
    i_mem_rdata = 32'h2222_2222;
    n_req = 1;
    tick;
    chk("dm_fill_we", 32'(o_mem_we), 32'd0);
    chk("dm_fill_addr", o_mem_addr, 32'h0000_0100);
    if (o_mem_req) n_req++;
    tick;
    i_mem_ack = 1'b0;
    chk("dm_memresp", 32'(o_memory_response), 32'd1);
    tick;
    tick;
    chk("dm_respv", 32'(o_resp_valid), 32'd1);
    chk("dm_rdata_zero", o_resp_rdata, 32'h0);
    chk("dm_nreq", 32'(n_req), 32'd2);
    tick;

    // replay misses again -> error, no further memory request
    issue(32'h0000_0200, 1'b0, 32'h0);
    i_cache_miss = 1'b1;
    tick;
    i_mem_ack   = 1'b1;
    i_mem_rdata = 32'h3333_3333;
    tick;
    i_mem_ack = 1'b0;
    tick;
    i_evict = 1'b1;
    tick;
    i_cache_miss = 1'b0;
    i_evict      = 1'b0;
    chk("rm_respv", 32'(o_resp_valid), 32'd1);
    chk("rm_err", 32'(o_resp_err), 32'd1);
    chk("rm_rdata", o_resp_rdata, 32'h0);
    chk("rm_memreq", 32'(o_mem_req), 32'd0);
    tick;

    // timeout: o_mem_req high exactly TIMEOUT_CYC cycles
    issue(32'h0000_0300, 1'b0, 32'h0);
    i_cache_miss = 1'b1;
    tick;
    i_cache_miss = 1'b0;
    n_req = 0;
    got_resp = 1'b0;
    got_err  = 1'b0;
    for (int k = 0; k < 8 && !got_resp; k++) begin
      if (o_resp_valid) begin
        got_resp = 1'b1;
        got_err  = o_resp_err;
      end else begin
        if (o_mem_req) n_req++;
        tick;
      end
    end
    chk("to_req_cycles", 32'(n_req), 32'd4);
    chk("to_resp", 32'(got_resp), 32'd1);
    chk("to_err", 32'(got_err), 32'd1);
    tick;

    // asynchronous reset during FILL
    issue(32'h0000_0400, 1'b0, 32'h0);
    i_cache_miss = 1'b1;
    tick;
    i_cache_miss = 1'b0;
    chk("ar_fill_req", 32'(o_mem_req), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("ar_memreq_drop", 32'(o_mem_req), 32'd0);
    chk("ar_ready", 32'(o_req_ready), 32'd1);
    #1 rst = 1'b1;
    n_resp = 0;
    for (int k = 0; k < 4; k++) begin
      tick;
      if (o_resp_valid) n_resp++;
    end
    chk("ar_no_resp", 32'(n_resp), 32'd0);
    issue(32'h0000_4040, 1'b0, 32'h0);
    i_cache_data = 32'h0BAD_F00D;
    tick;
    chk("ar_next_respv", 32'(o_resp_valid), 32'd1);
    chk("ar_next_rdata", o_resp_rdata, 32'h0BAD_F00D);
    tick;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sa_cache_ctrl.md
SA_CACHE_CTRL -- requirements
Module: sa_cache_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 255: max cycles waiting for i_mem_ack before abort (range 1..255, 8-bit counter).
REQ-002 SHALL have ports, clock and reset first (name, direction, width, meaning):
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- i_req_valid  in  1  CPU request valid.
- o_req_ready  out  1  controller can accept a request.
- i_req_addr  in  32  byte address; tag=[31:14], index=[13:6], offset=[5:0].
- i_req_we  in  1  1=write, 0=read.
- i_req_wdata  in  32  write data.
- o_resp_valid  out  1  one-cycle response strobe.
- o_resp_rdata  out  32  read data (0 for writes and errors).
- o_resp_err  out  1  qualifies o_resp_valid: timeout or replay miss.
- o_tag / o_index / o_offset  out  18/8/6  cache address fields.
- o_dataW  out  32  cache write data.
- o_memRW  out  1  cache op, 1=write.
- o_cache_access  out  1  cache lookup strobe.
- i_cache_miss  in  1  cache miss, combinational, valid during o_cache_access.
- i_cache_data  in  32  cache read data, valid during o_cache_access.
- i_evict / i_evict_data / i_evict_addr  in  1/32/32  dirty victim info, valid with miss.
- o_memory_line  out  32  refill line to cache.
- o_memory_response  out  1  one-cycle refill strobe to cache.
- o_mem_req / o_mem_we  out  1/1  memory request, 1=write-back.
- o_mem_addr / o_mem_wdata  out  32/32  memory address and write data.
- i_mem_ack / i_mem_rdata  in  1/32  memory completion and read data.

Function
REQ-003 SHALL implement FSM states IDLE, LOOKUP, WB, FILL, REFILL, RESP.
REQ-004 IDLE: o_req_ready=1; on i_req_valid&&o_req_ready SHALL register addr/we/wdata, clear replay flag, go LOOKUP; o_req_ready=0 in all other states.
REQ-005 LOOKUP: o_cache_access=1 for exactly one cycle, fields from registered request; hit -> RESP capturing i_cache_data (read) or 0 (write).
REQ-006 LOOKUP miss with replay flag clear: i_evict=1 -> register i_evict_addr/i_evict_data, go WB; i_evict=0 -> go FILL.
REQ-007 LOOKUP miss with replay flag set SHALL go RESP with o_resp_err=1 (no livelock).
REQ-008 WB: o_mem_req=1, o_mem_we=1, addr/wdata = registered victim; held stable until i_mem_ack; on ack -> FILL.
REQ-009 FILL: o_mem_req=1, o_mem_we=0, o_mem_addr={tag,index,6'b0}; on ack register i_mem_rdata into o_memory_line, go REFILL.
REQ-010 REFILL: o_memory_response=1 for exactly one cycle, set replay flag, go LOOKUP.
REQ-011 RESP: o_resp_valid=1 for exactly one cycle, no backpressure, then IDLE.
REQ-012 8-bit wait counter SHALL clear on entry to WB/FILL, increment each cycle without ack; reaching TIMEOUT_CYC -> drop o_mem_req, go RESP with o_resp_err=1.
REQ-013 Ack and timeout in same cycle: ack wins.
REQ-014 i_mem_ack outside WB/FILL SHALL be ignored; i_req_valid outside IDLE SHALL be ignored.
REQ-015 Latency: hit handshake at edge N -> LOOKUP cycle N+1, o_resp_valid during cycle N+2; clean miss with ack in first FILL cycle -> o_resp_valid 5 cycles after handshake edge; each WB adds >=1 cycle.
REQ-016 o_memRW/o_dataW SHALL equal registered we/wdata during LOOKUP, 0 otherwise.

Reset
REQ-017 rst low SHALL asynchronously force IDLE, counter 0, replay flag 0, all outputs 0 except o_req_ready=1.
REQ-018 Reset mid-WB/FILL SHALL drop o_mem_req immediately; in-flight request discarded, no response.

Verification
REQ-019 Read hit addr 0x0000_4040, cache data 0xDEADBEEF -> o_resp_valid cycle N+2, rdata 0xDEADBEEF, err 0.
REQ-020 Clean read miss addr 0x1234_5678, ack after 3 cycles rdata 0xCAFEF00D -> o_mem_addr 0x1234_5640, o_memory_response one pulse, replay hits, correct rdata.
REQ-021 Dirty miss, evict addr 0x0000_8000 data 0x11111111 -> WB write to 0x0000_8000 completes before FILL read; exactly two memory transactions.
REQ-022 TIMEOUT_CYC=4, no ack -> o_mem_req high exactly 4 cycles, then o_resp_valid with o_resp_err=1.
REQ-023 Replay lookup misses again -> o_resp_err=1, no third memory request.
REQ-024 rst asserted during FILL -> o_mem_req=0 asynchronously, o_req_ready=1, no o_resp_valid; next request serviced normally.
